// File: rtl/radio_capture.sv
// rtl/radio_capture.sv - eight-channel RC pulse-width capture with link timeout; optional macro RADIO_FAILSAFE_EN
module radio_capture #(
    parameter int         OFFSET_US    = 1000,
    parameter int         MIN_US       = 800,
    parameter int         MAX_US       = 2200,
    parameter int         TIMEOUT_MS   = 100,
    parameter logic [9:0] FAILSAFE_VAL = 10'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1mhz,
    input  logic [7:0]  radio_sig,
    output logic [79:0] radio_val,
    output logic [7:0]  radio_valid,
    output logic [7:0]  radio_update
);

`ifdef RADIO_FAILSAFE_EN
    localparam bit FAILSAFE_LOAD = 1'b1;
`else
    localparam bit FAILSAFE_LOAD = 1'b0;
`endif

    localparam logic [11:0] MIN_CNT       = 12'(MIN_US);
    localparam logic [11:0] MAX_CNT       = 12'(MAX_US);
    localparam logic [6:0]  TIMEOUT_REACH = 7'(TIMEOUT_MS - 1);
    localparam logic [9:0]  PRESC_LAST    = 10'd999;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    logic [7:0]         s1;
    logic [7:0]         s2;
    logic [7:0]         prev;
    logic [7:0]         rise;
    logic [7:0]         fall;
    logic [1:0]         settle;
    logic               settled;
    logic [9:0]         presc;
    logic               ms_tick;
    state_t             state      [8];
    state_t             state_next [8];
    logic [11:0]        cnt        [8];
    logic [11:0]        cnt_next   [8];
    logic [6:0]         ms_cnt     [8];
    logic signed [12:0] diff       [8];
    logic [9:0]         clamp      [8];
    logic [7:0]         accept;

    assign rise    = s2 & ~prev;
    assign fall    = ~s2 & prev;
    assign settled = (settle == 2'd2);
    assign ms_tick = tick_1mhz && (presc == PRESC_LAST);

    // Two-flop synchroniser plus edge-detect history for every pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 8'h00;
            s2   <= 8'h00;
            prev <= 8'h00;
        end else begin
            s1   <= radio_sig;
            s2   <= s1;
            prev <= s2;
        end
    end

    // s2 only reflects the pin two edges after reset, so WAIT_LOW may not trust it before then
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle <= 2'd0;
        end else if (!settled) begin
            settle <= settle + 2'd1;
        end
    end

    // Shared microsecond-to-millisecond prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= 10'd0;
        end else if (tick_1mhz) begin
            presc <= (presc == PRESC_LAST) ? 10'd0 : presc + 10'd1;
        end
    end

    // Per-channel FSM state and width counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                state[i] <= WAIT_LOW;
                cnt[i]   <= 12'd0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
        end
    end

    // Per-channel next state, width counting and accept decision
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            accept[i]     = 1'b0;
            case (state[i])
                WAIT_LOW: begin
                    if (settled && !s2[i]) begin
                        state_next[i] = WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (rise[i]) begin
                        cnt_next[i]   = 12'd0;
                        state_next[i] = MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall[i]) begin
                        state_next[i] = WAIT_RISE;
                        accept[i]     = (cnt[i] >= MIN_CNT);
                    end else if (tick_1mhz) begin
                        cnt_next[i] = cnt[i] + 12'd1;
                        if (cnt[i] >= MAX_CNT) begin
                            state_next[i] = WAIT_LOW;
                        end
                    end
                end
                default: begin
                    state_next[i] = WAIT_LOW;
                end
            endcase
        end
    end

    // Offset the measured width and clamp it into the 10-bit slot range
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            diff[i] = $signed({1'b0, cnt[i]}) - $signed(13'(OFFSET_US));
            if (diff[i] < 13'sd0) begin
                clamp[i] = 10'd0;
            end else if (diff[i] > 13'sd1023) begin
                clamp[i] = 10'd1023;
            end else begin
                clamp[i] = diff[i][9:0];
            end
        end
    end

    // Output slots, valid flags, update strobes and link-loss counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            radio_val    <= 80'd0;
            radio_valid  <= 8'h00;
            radio_update <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                ms_cnt[i] <= 7'd0;
            end
        end else begin
            radio_update <= accept;
            for (int i = 0; i < 8; i++) begin
                if (accept[i]) begin
                    radio_val[10*i +: 10] <= clamp[i];
                    radio_valid[i]        <= 1'b1;
                    ms_cnt[i]             <= 7'd0;
                end else if (ms_tick) begin
                    if (ms_cnt[i] != 7'h7F) begin
                        ms_cnt[i] <= ms_cnt[i] + 7'd1;
                    end
                    if (ms_cnt[i] == TIMEOUT_REACH) begin
                        radio_valid[i] <= 1'b0;
                        if (FAILSAFE_LOAD) begin
                            radio_val[10*i +: 10] <= FAILSAFE_VAL;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_radio_capture.sv
// tb/tb_radio_capture.sv - self-checking bench for radio_capture
module tb_radio_capture;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [7:0]  radio_sig = 8'h00;
    logic [79:0] radio_val;
    logic [7:0]  radio_valid;
    logic [7:0]  radio_update;

    typedef struct {
        logic [7:0] mask;
        int         width;
        int         exp;
        bit         upd;
    } vec_t;

    typedef struct {
        int ch;
        int val;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[9];
    int   model[8];
    int   checks = 0;
    int   errors = 0;
    int   upd_cycles = 0;
    int   u0;

    radio_capture #(.TIMEOUT_MS(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1mhz    (tick),
        .radio_sig    (radio_sig),
        .radio_val    (radio_val),
        .radio_valid  (radio_valid),
        .radio_update (radio_update)
    );

    always #5 clk = ~clk;

    // 1 MHz tick: high for one clk out of every two
    initial begin
        forever begin
            @(posedge clk);
            #1 tick = ~tick;
        end
    end

    function automatic int slot(input int ch);
        return int'(radio_val[10*ch +: 10]);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_near(input string name, input int act, input int req);
        checks++;
        if (act < req - 1 || act > req + 1) begin
            errors++;
            $display("FAIL %s actual %0d required %0d +-1", name, act, req);
        end
    endtask

    task automatic check_slots(input string name);
        for (int ch = 0; ch < 8; ch++) begin
            check_near(name, slot(ch), model[ch]);
        end
    endtask

    task automatic push_exp(input logic [7:0] mask, input int val);
        for (int ch = 0; ch < 8; ch++) begin
            if (mask[ch]) begin
                sb_q.push_back('{ch, val});
                model[ch] = val;
            end
        end
    endtask

    task automatic pulse(input logic [7:0] mask, input int width);
        @(posedge clk);
        #1 radio_sig = mask;
        repeat (2 * width) @(posedge clk);
        #1 radio_sig = 8'h00;
        repeat (100) @(posedge clk);
    endtask

    // Scoreboard: every update strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && radio_update != 8'h00) begin
            upd_cycles++;
            for (int ch = 0; ch < 8; ch++) begin
                if (radio_update[ch]) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_update ch %0d value %0d", ch, slot(ch));
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("sb_channel", ch, mon_e.ch);
                        check_near("sb_value", slot(ch), mon_e.val);
                    end
                end
            end
        end
    end

    initial begin
        vecs[0] = '{8'h01, 1500, 500,  1'b1};
        vecs[1] = '{8'h08, 1000, 0,    1'b1};
        vecs[2] = '{8'h08, 2150, 1023, 1'b1};
        vecs[3] = '{8'h20, 700,  0,    1'b0};
        vecs[4] = '{8'h20, 2500, 0,    1'b0};
        vecs[5] = '{8'h20, 1200, 200,  1'b1};
        vecs[6] = '{8'h20, 790,  0,    1'b0};
        vecs[7] = '{8'h40, 810,  0,    1'b1};
        vecs[8] = '{8'hFF, 1800, 800,  1'b1};
        for (int ch = 0; ch < 8; ch++) model[ch] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_slots("reset_val");
        check("reset_valid", int'(radio_valid), 0);
        check("reset_update", int'(radio_update), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        // Table-driven pulse vectors
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].upd) push_exp(vecs[v].mask, vecs[v].exp);
            u0 = upd_cycles;
            pulse(vecs[v].mask, vecs[v].width);
            check($sformatf("v%0d_update_cycles", v), upd_cycles - u0, vecs[v].upd ? 1 : 0);
            check_slots($sformatf("v%0d_slots", v));
            if (vecs[v].upd) begin
                check($sformatf("v%0d_valid", v), int'(radio_valid & vecs[v].mask), int'(vecs[v].mask));
            end
        end

        // Link-loss timeout on all channels
        push_exp(8'hFF, 500);
        u0 = upd_cycles;
        pulse(8'hFF, 1500);
        check("tmo_update_cycles", upd_cycles - u0, 1);
        repeat (5400) @(posedge clk);
        #1 check("tmo_valid_before", int'(radio_valid), 8'hFF);
        repeat (2900) @(posedge clk);
        #1 check("tmo_valid_after", int'(radio_valid), 0);
`ifdef RADIO_FAILSAFE_EN
        for (int ch = 0; ch < 8; ch++) model[ch] = 0;
`endif
        check_slots("tmo_slots");

        // Reset asserted 600 us into a pulse on ch1
        @(posedge clk);
        #1 radio_sig = 8'h02;
        repeat (1200) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int ch = 0; ch < 8; ch++) model[ch] = 0;
        check_slots("midrst_val");
        check("midrst_valid", int'(radio_valid), 0);
        check("midrst_update", int'(radio_update), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        u0 = upd_cycles;
        repeat (1800) @(posedge clk);
        #1 radio_sig = 8'h00;
        repeat (100) @(posedge clk);
        check("midrst_partial_updates", upd_cycles - u0, 0);
        push_exp(8'h02, 500);
        u0 = upd_cycles;
        pulse(8'h02, 1500);
        check("midrst_next_updates", upd_cycles - u0, 1);
        check_slots("midrst_next_slots");

        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/radio_capture.md
# radio_capture

Eight-channel RC receiver pulse-width capture stage feeding the radio bus (`radio_val`) consumed by the flags and ESC output stages. Each `radio_sig` line is synchronised, its high time measured in microseconds from a 1 MHz tick enable, range-checked, offset and clamped to a 10-bit value. Each channel also has a link-loss timeout.

## Interface
- `OFFSET_US`, default 1000: subtracted from the measured width before clamping.
- `MIN_US`, default 800: shortest accepted pulse, in µs.
- `MAX_US`, default 2200: longest accepted pulse, in µs.
- `TIMEOUT_MS`, default 100: a channel with no accepted pulse for this long is invalid.
- `FAILSAFE_VAL`, default 10'd0: value forced on timeout (only with `RADIO_FAILSAFE_EN`).
- `clk`, input, 1 bit: system clock; the only clock.
- `rst`, input, 1 bit: reset, **asynchronous, active-high**.
- `tick_1mhz`, input, 1 bit: one-`clk` pulse every 1 µs; synchronous to `clk`.
- `radio_sig`, input, 8 bits: raw receiver PWM lines; asynchronous to `clk`.
- `radio_val`, output, 80 bits: channel n in bits [10n+9:10n].
- `radio_valid`, output, 8 bits: per-channel link-valid flag.
- `radio_update`, output, 8 bits: one-`clk` pulse when a channel's value is refreshed.

## Operation
- Per channel, the input path is a 2-flop synchroniser (`s1`, `s2`) followed by a `prev` register.
  - `rise` = `s2 & ~prev`.
  - `fall` = `~s2 & prev`.
- Per-channel state machine:
  - WAIT_LOW (the reset state): go to WAIT_RISE when `s2`=0. This stops a partial pulse after reset from being measured.
  - WAIT_RISE: on `rise`, clear `cnt` to 0 and go to MEASURE.
  - MEASURE:
    - `cnt` (12 bits) increments on each `tick_1mhz`.
    - If `cnt` > `MAX_US`, abort to WAIT_LOW (no update).
    - On `fall` with `cnt` < `MIN_US`, reject and go to WAIT_RISE.
    - Otherwise accept and go to WAIT_RISE.
- On accept:
  - Value = `cnt` − `OFFSET_US`, clamped to 0..1023. The subtraction uses a signed 13-bit intermediate.
  - Write the value to the channel's slot.
  - Set `radio_update[n]` high for 1 cycle.
  - Set `radio_valid[n]` to 1.
  - Clear the channel's timeout counter.
- Simultaneous events:
  - `rise` and `tick_1mhz` in the same cycle: the clear wins and `cnt` = 0.
  - `fall` and `tick_1mhz` in the same cycle: the tick is not counted.
- Timeout:
  - A shared prescaler counts 1000 ticks and emits `ms_tick`.
  - Each channel has a 7-bit ms counter that saturates.
  - When a channel's counter reaches `TIMEOUT_MS`, `radio_valid[n]` goes to 0.
  - On timeout, `radio_val` follows the Configuration section.
  - An accept and `ms_tick` in the same cycle: the accept wins and the counter = 0.
- Channels are fully independent. Simultaneous accepts on several channels all update in the same cycle.

## Timing
- Reset values:
  - `radio_val` = 0, `radio_valid` = 0, `radio_update` = 0.
  - All FSMs in WAIT_LOW.
  - `cnt`, the prescaler and the ms counters = 0.
  - Synchroniser flops = 0.
- Edge latency: a pin transition sampled into `s1` at edge N is seen as `rise`/`fall` during the cycle after edge N+1. The resulting `radio_val` and `radio_update` registers change at edge N+2.
- Measurement error is ±1 µs, from tick quantisation and the synchroniser.
- `radio_update` never stays high for more than one cycle. There are no back-to-back pulses on one channel, because the minimum pulse plus gap spans many cycles.
- A pulse wider than `MAX_US` is aborted at the tick where `cnt` reaches `MAX_US`+1.
- Reset asserted mid-pulse:
  - All outputs clear immediately (asynchronous).
  - After reset release, the pulse in progress is ignored via WAIT_LOW.

## Configuration
- `RADIO_FAILSAFE_EN` defined: on timeout, the channel slot is loaded with `FAILSAFE_VAL` in the same cycle that `radio_valid[n]` falls.
- `RADIO_FAILSAFE_EN` undefined: on timeout, the slot holds its last accepted value and only `radio_valid[n]` falls.

## Test plan
- 1500 µs pulse on ch0 -> `radio_val[9:0]`=500 ±1, `radio_update[0]` pulses once, `radio_valid[0]`=1, other channels unchanged.
- 1000 µs and 2150 µs pulses on ch3 -> values 0 and 1023 (clamped), two update pulses.
- 700 µs pulse, then 2500 µs pulse on ch5 -> no update, `radio_val` unchanged, FSM returns to WAIT_RISE / WAIT_LOW; the next 1200 µs pulse gives 200.
- Valid 1500 µs pulses on all channels, then silence for 120 ms -> `radio_valid`=0x00 at 100 ms ±1 ms. `radio_val` = 0 with `RADIO_FAILSAFE_EN`; 500 per channel without it.
- Reset pulsed 600 µs into a 1500 µs pulse on ch1 -> outputs clear asynchronously, that pulse yields no update, and the following 1500 µs pulse gives 500.
- Identical 1800 µs pulses on all 8 channels simultaneously -> `radio_update`=0xFF in one cycle and every slot = 800.
